// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router output-side synchroniser.
package router_pkg;

    localparam int ROUTER_NUM_CH  = 3;
    localparam int ROUTER_TIMEOUT = 30;
    localparam int ROUTER_DROP_W  = 8;
    localparam int ROUTER_MAX_CH  = 16;

    // One-hot decode of idx; all zero when idx falls outside the first n channels.
    function automatic logic [ROUTER_MAX_CH-1:0] onehot(input int unsigned idx,
                                                        input int unsigned n);
        logic [ROUTER_MAX_CH-1:0] v;
        v = '0;
        if ((idx < n) && (idx < ROUTER_MAX_CH)) begin
            v[idx[3:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One channel's stall watchdog: counts consecutive stalled cycles, pulses
// soft_reset to flush the FIFO and keeps a saturating count of flushes.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT),
    parameter int DROP_W  = ROUTER_DROP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              empty,
    input  logic              read_enb,
    output logic              soft_reset,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic             stall;
    logic             expire;

    // Data waiting and nobody reading it.
    assign stall  = ~empty & ~read_enb;
    assign expire = stall && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            soft_reset <= 1'b0;
            drop_cnt   <= '0;
        end else if (expire) begin
            count      <= '0;
            soft_reset <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (stall) begin
            count      <= count + 1'b1;
            soft_reset <= 1'b0;
        end else begin
            count      <= '0;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header destination, steers FIFO writes,
// muxes back the addressed full flag and runs one stall timer per channel.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int DROP_W  = ROUTER_DROP_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     detect_add,
    input  logic [ADDR_W-1:0]        data_in,
    input  logic                     write_enb_reg,
    input  logic [NUM_CH-1:0]        full,
    input  logic [NUM_CH-1:0]        empty,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH-1:0]        write_enb,
    output logic                     fifo_full,
    output logic [NUM_CH-1:0]        vld_out,
    output logic [NUM_CH-1:0]        soft_reset,
    output logic                     addr_err,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt
);

    localparam int                CNT_W      = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] dest;
    logic              dest_valid;
    logic              hdr_ok;
    logic [NUM_CH-1:0] sel_oh;

    assign hdr_ok = {1'b0, data_in} < NUM_CH_EXT;

    // An out-of-range header invalidates the destination but leaves dest alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest       <= '0;
            dest_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else if (detect_add) begin
            if (hdr_ok) begin
                dest       <= data_in;
                dest_valid <= 1'b1;
                addr_err   <= 1'b0;
            end else begin
                dest_valid <= 1'b0;
                addr_err   <= 1'b1;
            end
        end else begin
            addr_err <= 1'b0;
        end
    end

    assign sel_oh    = NUM_CH'(onehot(32'(dest), NUM_CH));
    assign write_enb = (write_enb_reg && dest_valid) ? sel_oh : '0;
    assign fifo_full = dest_valid & (|(full & sel_oh));
    assign vld_out   = ~empty;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W),
            .DROP_W  (DROP_W)
        ) u_timer (
            .clock      (clock),
            .reset      (reset),
            .empty      (empty[i]),
            .read_enb   (read_enb[i]),
            .soft_reset (soft_reset[i]),
            .drop_cnt   (drop_cnt[i*DROP_W +: DROP_W])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: a 3-channel/TIMEOUT=30 instance and a
// 5-channel/TIMEOUT=4 instance, checked through an expectation queue.
module tb_router_sync_n;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        detect_add, write_enb_reg, fifo_full, addr_err;
    logic [1:0]  data_in;
    logic [2:0]  full, empty, read_enb, write_enb, vld_out, soft_reset;
    logic [23:0] drop_cnt;

    logic        detect_add5, wer5, ff5, ae5;
    logic [2:0]  data_in5;
    logic [4:0]  full5, empty5, read5, we5, vld5, sr5;
    logic [39:0] drop5;

    router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30), .DROP_W(8)) u_dut (
        .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
        .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
        .soft_reset(soft_reset), .addr_err(addr_err), .drop_cnt(drop_cnt));

    router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4), .DROP_W(8)) u_dut5 (
        .clock(clock), .reset(reset), .detect_add(detect_add5), .data_in(data_in5),
        .write_enb_reg(wer5), .full(full5), .empty(empty5), .read_enb(read5),
        .write_enb(we5), .fifo_full(ff5), .vld_out(vld5),
        .soft_reset(sr5), .addr_err(ae5), .drop_cnt(drop5));

    typedef enum int {O_WE, O_FF, O_SR, O_AE, O_DROP, O_VLD, O_WE5, O_FF5, O_SR5, O_DROP5} osel_t;
    typedef struct {
        string       tag;
        osel_t       sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] observe(osel_t s);
        case (s)
            O_WE:    return 64'(write_enb);
            O_FF:    return 64'(fifo_full);
            O_SR:    return 64'(soft_reset);
            O_AE:    return 64'(addr_err);
            O_DROP:  return 64'(drop_cnt);
            O_VLD:   return 64'(vld_out);
            O_WE5:   return 64'(we5);
            O_FF5:   return 64'(ff5);
            O_SR5:   return 64'(sr5);
            O_DROP5: return 64'(drop5);
            default: return '1;
        endcase
    endfunction

    task automatic expect_out(input string tag, input osel_t s, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t        x;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = observe(x.sel);
            total++;
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] d;

        reset = 1'b1;
        detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b1;
        full = 3'b111; empty = 3'b111; read_enb = 3'b000;
        detect_add5 = 1'b0; data_in5 = 3'd0; wer5 = 1'b1;
        full5 = 5'b11111; empty5 = 5'b11111; read5 = 5'b00000;
        #2;
        expect_out("rst_we",   O_WE,   64'(3'b000));
        expect_out("rst_ff",   O_FF,   64'(1'b0));
        expect_out("rst_sr",   O_SR,   64'(3'b000));
        expect_out("rst_ae",   O_AE,   64'(1'b0));
        expect_out("rst_drop", O_DROP, 64'(24'h0));
        expect_out("rst_we5",  O_WE5,  64'(5'b00000));
        expect_out("rst_ff5",  O_FF5,  64'(1'b0));
        drain();
        tick();
        tick();
        reset = 1'b0;
        full = 3'b100;
        #1;
        expect_out("no_dest_we", O_WE, 64'(3'b000));
        drain();

        // Header to channel 2; the header cycle itself still steers to nothing.
        detect_add = 1'b1; data_in = 2'd2;
        #1;
        expect_out("hdr2_cycle_we", O_WE, 64'(3'b000));
        expect_out("hdr2_cycle_ff", O_FF, 64'(1'b0));
        drain();
        tick();
        detect_add = 1'b0;
        #1;
        expect_out("ch2_we", O_WE, 64'(3'b100));
        expect_out("ch2_ff", O_FF, 64'(1'b1));
        expect_out("ch2_ae", O_AE, 64'(1'b0));
        drain();

        // Header to channel 0 while writing: old steering until the edge.
        detect_add = 1'b1; data_in = 2'd0;
        #1;
        expect_out("hdr0_cycle_we", O_WE, 64'(3'b100));
        drain();
        tick();
        detect_add = 1'b0;
        #1;
        expect_out("ch0_we", O_WE, 64'(3'b001));
        expect_out("ch0_ff", O_FF, 64'(1'b0));
        drain();

        // Out-of-range header.
        full = 3'b111;
        detect_add = 1'b1; data_in = 2'd3;
        #1;
        expect_out("hdr3_cycle_we", O_WE, 64'(3'b001));
        drain();
        tick();
        detect_add = 1'b0;
        #1;
        expect_out("bad_ae", O_AE, 64'(1'b1));
        expect_out("bad_we", O_WE, 64'(3'b000));
        expect_out("bad_ff", O_FF, 64'(1'b0));
        drain();
        tick();
        expect_out("bad_ae_drop", O_AE, 64'(1'b0));
        expect_out("bad_we_hold", O_WE, 64'(3'b000));
        drain();
        write_enb_reg = 1'b0;

        // Channel 1 stalled for 60 cycles: pulses after cycles 30 and 60.
        empty = 3'b101;
        #1;
        expect_out("vld", O_VLD, 64'(3'b010));
        drain();
        for (int k = 1; k <= 60; k++) begin
            expect_out("stall_sr", O_SR, 64'((k == 30 || k == 60) ? 3'b010 : 3'b000));
            tick();
            if (k == 30) expect_out("stall_drop1", O_DROP, 64'(24'h000100));
            if (k == 60) expect_out("stall_drop2", O_DROP, 64'(24'h000200));
            drain();
        end
        empty = 3'b111;
        expect_out("idle_sr", O_SR, 64'(3'b000));
        tick();
        drain();

        // Read on cycle 29 restarts the window; pulse 30 stalled cycles later.
        empty = 3'b101;
        for (int k = 1; k <= 59; k++) begin
            read_enb = (k == 29) ? 3'b010 : 3'b000;
            expect_out("read_sr", O_SR, 64'((k == 59) ? 3'b010 : 3'b000));
            tick();
            drain();
        end
        read_enb = 3'b000;
        expect_out("read_drop", O_DROP, 64'(24'h000300));
        drain();

        // Mid-packet to channel 2, 20 stalled cycles, then async reset.
        empty = 3'b111;
        detect_add = 1'b1; data_in = 2'd2;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        empty = 3'b101;
        for (int k = 1; k <= 20; k++) begin
            expect_out("pre_rst_sr", O_SR, 64'(3'b000));
            tick();
            drain();
        end
        expect_out("pkt_we", O_WE, 64'(3'b100));
        drain();
        reset = 1'b1;
        #1;
        expect_out("async_we",   O_WE,   64'(3'b000));
        expect_out("async_ff",   O_FF,   64'(1'b0));
        expect_out("async_sr",   O_SR,   64'(3'b000));
        expect_out("async_drop", O_DROP, 64'(24'h0));
        drain();
        tick();
        reset = 1'b0;
        #1;
        expect_out("post_rst_we", O_WE, 64'(3'b000));
        drain();
        for (int k = 1; k <= 30; k++) begin
            expect_out("post_rst_sr", O_SR, 64'((k == 30) ? 3'b010 : 3'b000));
            tick();
            drain();
        end
        expect_out("post_rst_drop", O_DROP, 64'(24'h000100));
        drain();
        empty = 3'b111;
        write_enb_reg = 1'b0;

        // Five-channel build: steering to the top channel.
        detect_add5 = 1'b1; data_in5 = 3'd4; full5 = 5'b10000;
        tick();
        detect_add5 = 1'b0;
        #1;
        expect_out("ch4_we5", O_WE5, 64'(5'b10000));
        expect_out("ch4_ff5", O_FF5, 64'(1'b1));
        drain();

        // All five stalled: simultaneous pulses every 4 cycles, counts saturate.
        empty5 = 5'b00000;
        for (int k = 1; k <= 1040; k++) begin
            expect_out("sat_sr5", O_SR5, 64'((k % 4 == 0) ? 5'b11111 : 5'b00000));
            tick();
            if (k % 4 == 0) begin
                d = (k / 4 > 255) ? 8'd255 : 8'(k / 4);
                expect_out("sat_drop5", O_DROP5, 64'({5{d}}));
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
